// File: rtl/mux_4x1_if.sv
// Bus bundle for the registered 4-to-1 multiplexer: select, four data sources,
// and the captured result with its valid qualifier.
interface mux_4x1_if #(
  parameter int WIDTH = 1
);
  // Valid-only handshake with no ready. A capture happens on every rising
  // edge where valid_i=1 and reset is low. valid_o is high for exactly the one
  // cycle after that capture. The sink must always accept, because nothing
  // stalls the block.
  logic [1:0]       sel_i;
  logic [WIDTH-1:0] x0_i;
  logic [WIDTH-1:0] x1_i;
  logic [WIDTH-1:0] x2_i;
  logic [WIDTH-1:0] x3_i;
  logic             valid_i;
  logic [WIDTH-1:0] y_o;
  logic             valid_o;

  modport master (
    output sel_i, x0_i, x1_i, x2_i, x3_i, valid_i,
    input  y_o, valid_o
  );

  modport slave (
    input  sel_i, x0_i, x1_i, x2_i, x3_i, valid_i,
    output y_o, valid_o
  );
endinterface

// File: rtl/mux_4x1.sv
// Registered 4-to-1 multiplexer. The source chosen by sel_i is captured into
// y_o when valid_i is high. valid_o marks the cycle that follows each capture.
module mux_4x1 #(
  parameter int WIDTH = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  mux_4x1_if.slave  bus
);

  logic [WIDTH-1:0] sel_data;

  // Full decode of all four codes. Sources that are not selected never reach sel_data.
  always_comb begin
    sel_data = bus.x0_i;
    case (bus.sel_i)
      2'b00: sel_data = bus.x0_i;
      2'b01: sel_data = bus.x1_i;
      2'b10: sel_data = bus.x2_i;
      2'b11: sel_data = bus.x3_i;
    endcase
  end

  // Reset has priority, so a capture requested during reset is dropped.
  // When valid_i is low, y_o holds its previous value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.y_o     <= '0;
      bus.valid_o <= 1'b0;
    end else begin
      bus.valid_o <= bus.valid_i;
      if (bus.valid_i) begin
        bus.y_o <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_mux_4x1.sv
// Directed bench for mux_4x1. It uses a 1-bit instance for the behavioural
// scenarios and an 8-bit instance for the checks that distinguish sources bit for bit.
module tb_mux_4x1;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mux_4x1_if #(.WIDTH(1)) b1 ();
  mux_4x1_if #(.WIDTH(8)) b8 ();

  mux_4x1 #(.WIDTH(1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(b1));
  mux_4x1 #(.WIDTH(8)) dut8 (.clk_i(clk), .rst_i(rst), .bus(b8));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic drive1(input logic [1:0] s, input logic [3:0] x, input logic v);
    b1.sel_i   = s;
    b1.x0_i    = x[0];
    b1.x1_i    = x[1];
    b1.x2_i    = x[2];
    b1.x3_i    = x[3];
    b1.valid_i = v;
  endtask

  task automatic drive8(input logic [1:0] s, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d, input logic v);
    b8.sel_i   = s;
    b8.x0_i    = a;
    b8.x1_i    = b;
    b8.x2_i    = c;
    b8.x3_i    = d;
    b8.valid_i = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive1(2'b10, 4'b1111, 1'b1);
    drive8(2'b01, 8'hff, 8'hff, 8'hff, 8'hff, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (b1.y_o !== 1'b0 || b1.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL reset1[%0d]: got y=%b v=%b, want y=0 v=0", i, b1.y_o, b1.valid_o);
      end
      checks++;
      if (b8.y_o !== 8'h00 || b8.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL reset8[%0d]: got y=%h v=%b, want y=00 v=0", i, b8.y_o, b8.valid_o);
      end
    end
    rst = 1'b0;
    drive8(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    checks++;
    if (b1.y_o !== 1'b1 || b1.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL first_capture: got y=%b v=%b, want y=1 v=1", b1.y_o, b1.valid_o);
    end
    checks++;
    if (b8.y_o !== 8'h00 || b8.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL idle8: got y=%h v=%b, want y=00 v=0", b8.y_o, b8.valid_o);
    end
  endtask

  task automatic test_select_uniform();
    for (int s = 0; s < 4; s++) begin
      for (int d = 0; d < 2; d++) begin
        drive1(2'(s), (d == 1) ? 4'b1111 : 4'b0000, 1'b1);
        tick();
        checks++;
        if (b1.y_o !== 1'(d) || b1.valid_o !== 1'b1) begin
          errors++;
          $display("FAIL uniform sel=%0d d=%0d: got y=%b v=%b, want y=%0d v=1",
                   s, d, b1.y_o, b1.valid_o, d);
        end
      end
    end
  endtask

  task automatic test_one_hot();
    logic [7:0] cst [4];
    cst[0] = 8'h11; cst[1] = 8'h22; cst[2] = 8'h44; cst[3] = 8'h88;
    for (int h = 0; h < 4; h++) begin
      for (int s = 0; s < 4; s++) begin
        drive1(2'(s), 4'(1 << h), 1'b1);
        tick();
        checks++;
        if (b1.y_o !== ((s == h) ? 1'b1 : 1'b0) || b1.valid_o !== 1'b1) begin
          errors++;
          $display("FAIL onehot hot=%0d sel=%0d: got y=%b v=%b, want y=%0d v=1",
                   h, s, b1.y_o, b1.valid_o, (s == h));
        end
      end
    end
    for (int s = 0; s < 4; s++) begin
      drive8(2'(s), 8'h11, 8'h22, 8'h44, 8'h88, 1'b1);
      tick();
      checks++;
      if (b8.y_o !== cst[s] || b8.valid_o !== 1'b1) begin
        errors++;
        $display("FAIL wide sel=%0d: got y=%h v=%b, want y=%h v=1", s, b8.y_o, b8.valid_o, cst[s]);
      end
    end
    // unselected sources driven unknown must not leak into y_o
    drive8(2'b10, 8'hxx, 8'hzz, 8'h5a, 8'hxx, 1'b1);
    tick();
    checks++;
    if (b8.y_o !== 8'h5a || b8.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL wide_isolate: got y=%h v=%b, want y=5a v=1", b8.y_o, b8.valid_o);
    end
    drive8(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    checks++;
    if (b8.y_o !== 8'h5a || b8.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL wide_hold: got y=%h v=%b, want y=5a v=0", b8.y_o, b8.valid_o);
    end
  endtask

  task automatic test_hold();
    drive1(2'b00, 4'b0001, 1'b1);
    tick();
    checks++;
    if (b1.y_o !== 1'b1 || b1.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_capture: got y=%b v=%b, want y=1 v=1", b1.y_o, b1.valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      drive1(2'(i + 1), (i % 2 == 0) ? 4'b0000 : 4'b1110, 1'b0);
      tick();
      checks++;
      if (b1.y_o !== 1'b1 || b1.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: got y=%b v=%b, want y=1 v=0", i, b1.y_o, b1.valid_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_seq;
    exp_seq = 4'b1010;
    for (int s = 0; s < 4; s++) begin
      drive1(2'(s), 4'b1010, 1'b1);
      tick();
      checks++;
      if (b1.y_o !== exp_seq[s] || b1.valid_o !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d]: got y=%b v=%b, want y=%b v=1", s, b1.y_o, b1.valid_o, exp_seq[s]);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive1(2'b01, 4'b0010, 1'b1);
    tick();
    checks++;
    if (b1.y_o !== 1'b1 || b1.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: got y=%b v=%b, want y=1 v=1", b1.y_o, b1.valid_o);
    end
    rst = 1'b1;
    drive1(2'b11, 4'b1000, 1'b1);
    tick();
    checks++;
    if (b1.y_o !== 1'b0 || b1.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got y=%b v=%b, want y=0 v=0", b1.y_o, b1.valid_o);
    end
    rst = 1'b0;
    drive1(2'b11, 4'b1000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (b1.y_o !== 1'b0 || b1.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale[%0d]: got y=%b v=%b, want y=0 v=0", i, b1.y_o, b1.valid_o);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    drive1(2'b00, 4'b0000, 1'b0);
    drive8(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_select_uniform();
    test_one_hot();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
